// File: rtl/fft_pkg.sv
// Shared FFT pipeline constants, phase encodings and product rounding.
package fft_pkg;

  localparam int DATA_W  = 24;
  localparam int TW_FRAC = 8;
  localparam int DEPTH   = 16;
  localparam int PROD_W  = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    PH_FILL = 2'd0,
    PH_SUM  = 2'd1,
    PH_TW   = 2'd2
  } phase_t;

  localparam logic [PROD_W-1:0] RND = {
    {(PROD_W - TW_FRAC){1'b0}},
    1'b1,
    {(TW_FRAC - 1){1'b0}}
  };

  // Round half up, then drop the twiddle fraction; wraps to DATA_W.
  function automatic logic signed [DATA_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p
  );
    logic signed [PROD_W-1:0] t;
    t = p + RND;
    return DATA_W'(t >>> TW_FRAC);
  endfunction

endpackage

// File: rtl/sdf_r2_stage16_if.sv
// Stream, twiddle-ROM and output bundle of the radix-2 SDF stage.
interface sdf_r2_stage16_if;
  import fft_pkg::*;

  logic                     in_valid;
  logic signed [DATA_W-1:0] din_r;
  logic signed [DATA_W-1:0] din_i;
  logic [3:0]               tw_idx;
  logic signed [DATA_W-1:0] w_r;
  logic signed [DATA_W-1:0] w_i;
  logic                     dout_valid;
  logic signed [DATA_W-1:0] dout_r;
  logic signed [DATA_W-1:0] dout_i;
  logic [1:0]               phase;

  modport slave (
    input  in_valid, din_r, din_i,
    input  w_r, w_i,
    output tw_idx,
    output dout_valid, dout_r, dout_i,
    output phase
  );

  modport master (
    output in_valid, din_r, din_i,
    output w_r, w_i,
    input  tw_idx,
    input  dout_valid, dout_r, dout_i,
    input  phase
  );

endinterface

// File: rtl/sdf_delay_line.sv
// Enable-gated complex shift register; head is the entry pushed DEPTH
// accepted samples ago.
module sdf_delay_line #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] push_r,
  input  logic signed [DATA_W-1:0] push_i,
  output logic signed [DATA_W-1:0] head_r,
  output logic signed [DATA_W-1:0] head_i
);

  logic signed [DATA_W-1:0] mem_r [DEPTH];
  logic signed [DATA_W-1:0] mem_i [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
        mem_i[i] <= '0;
      end
    end else if (en) begin
      mem_r[0] <= push_r;
      mem_i[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
        mem_i[i] <= mem_i[i-1];
      end
    end
  end

  assign head_r = mem_r[DEPTH-1];
  assign head_i = mem_i[DEPTH-1];

endmodule

// File: rtl/sdf_r2_stage16.sv
// Radix-2 DIF single-path delay-feedback stage, 32-point span:
// butterfly in the upper half, twiddle multiply on the fed-back differences.
module sdf_r2_stage16
  import fft_pkg::*;
(
  input logic             clk,
  input logic             rst,
  sdf_r2_stage16_if.slave bus
);

  logic [4:0]               cnt;
  logic                     primed;
  logic                     half;
  logic                     acc;
  phase_t                   ph_q;
  logic                     dv_q;
  logic signed [DATA_W-1:0] do_r;
  logic signed [DATA_W-1:0] do_i;

  logic signed [DATA_W-1:0] d_r;
  logic signed [DATA_W-1:0] d_i;
  logic signed [DATA_W-1:0] sum_r;
  logic signed [DATA_W-1:0] sum_i;
  logic signed [DATA_W-1:0] dif_r;
  logic signed [DATA_W-1:0] dif_i;
  logic signed [DATA_W-1:0] push_r;
  logic signed [DATA_W-1:0] push_i;

  logic signed [PROD_W-1:0] dr_x;
  logic signed [PROD_W-1:0] di_x;
  logic signed [PROD_W-1:0] wr_x;
  logic signed [PROD_W-1:0] wi_x;
  logic signed [PROD_W-1:0] pr;
  logic signed [PROD_W-1:0] pi;
  logic signed [DATA_W-1:0] mul_r;
  logic signed [DATA_W-1:0] mul_i;

  assign acc  = bus.in_valid;
  assign half = cnt[4];

  sdf_delay_line #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_dl (
    .clk    (clk),
    .rst    (rst),
    .en     (acc),
    .push_r (push_r),
    .push_i (push_i),
    .head_r (d_r),
    .head_i (d_i)
  );

  assign sum_r = d_r + bus.din_r;
  assign sum_i = d_i + bus.din_i;
  assign dif_r = d_r - bus.din_r;
  assign dif_i = d_i - bus.din_i;

  // Upper half feeds back the differences for next frame's twiddle pass.
  assign push_r = half ? dif_r : bus.din_r;
  assign push_i = half ? dif_i : bus.din_i;

  assign dr_x = PROD_W'(d_r);
  assign di_x = PROD_W'(d_i);
  assign wr_x = PROD_W'(bus.w_r);
  assign wi_x = PROD_W'(bus.w_i);

  assign pr    = dr_x * wr_x - di_x * wi_x;
  assign pi    = dr_x * wi_x + di_x * wr_x;
  assign mul_r = round_shift(pr);
  assign mul_i = round_shift(pi);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      primed <= 1'b0;
      ph_q   <= PH_FILL;
      dv_q   <= 1'b0;
      do_r   <= '0;
      do_i   <= '0;
    end else begin
      dv_q <= 1'b0;
      if (acc) begin
        cnt <= cnt + 5'd1;
        if (cnt == 5'd15) primed <= 1'b1;
        if (half) begin
          dv_q <= 1'b1;
          do_r <= sum_r;
          do_i <= sum_i;
          ph_q <= PH_SUM;
        end else if (primed) begin
          dv_q <= 1'b1;
          do_r <= mul_r;
          do_i <= mul_i;
          ph_q <= PH_TW;
        end else begin
          ph_q <= PH_FILL;
        end
      end
    end
  end

  assign bus.tw_idx     = cnt[3:0];
  assign bus.dout_valid = dv_q;
  assign bus.dout_r     = do_r;
  assign bus.dout_i     = do_i;
  assign bus.phase      = ph_q;

endmodule

// File: tb/tb_sdf_r2_stage16.sv
// Bench for sdf_r2_stage16: frame-level DIF reference model,
// directed spec cases plus randomized frames with random stalls.
module tb_sdf_r2_stage16;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdf_r2_stage16_if bus ();

  sdf_r2_stage16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // W^k = round(256 * exp(-j*2*pi*k/32))
  localparam int TWR[16] = '{
    256, 251, 237, 213, 181, 142, 98, 50,
    0, -50, -98, -142, -181, -213, -237, -251
  };
  localparam int TWI[16] = '{
    0, -50, -98, -142, -181, -213, -237, -251,
    -256, -251, -237, -213, -181, -142, -98, -50
  };

  assign bus.w_r = DATA_W'(TWR[bus.tw_idx]);
  assign bus.w_i = DATA_W'(TWI[bus.tw_idx]);

  int tests = 0;
  int fails = 0;
  int idx;
  int ph_exp;

  logic signed [23:0] sr[$], si[$];
  logic signed [23:0] er[$], ei[$];
  logic signed [23:0] gr[$], gi[$];

  task automatic check(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [23:0] wrap(input longint v);
    return v[23:0];
  endfunction

  task automatic cmul(input longint ar, input longint ai,
                      input int k,
                      output logic signed [23:0] yr,
                      output logic signed [23:0] yi);
    longint p;
    longint q;
    p  = ar * TWR[k] - ai * TWI[k];
    q  = ar * TWI[k] + ai * TWR[k];
    yr = wrap((p + 128) >>> 8);
    yi = wrap((q + 128) >>> 8);
  endtask

  // Per frame: 16 butterfly sums, then 16 rotated differences.
  task automatic build_expected();
    logic signed [23:0] yr, yi, a, b, c, e;
    er.delete();
    ei.delete();
    for (int f = 0; f < sr.size() / 32; f++) begin
      for (int j = 0; j < 16; j++) begin
        er.push_back(wrap(longint'(sr[f*32+j]) + sr[f*32+j+16]));
        ei.push_back(wrap(longint'(si[f*32+j]) + si[f*32+j+16]));
      end
      for (int j = 0; j < 16; j++) begin
        a = sr[f*32+j];
        b = sr[f*32+j+16];
        c = si[f*32+j];
        e = si[f*32+j+16];
        cmul(wrap(longint'(a) - b), wrap(longint'(c) - e), j, yr, yi);
        er.push_back(yr);
        ei.push_back(yi);
      end
    end
  endtask

  task automatic send(input bit v,
                      input logic signed [23:0] r,
                      input logic signed [23:0] i);
    bit expv;
    @(negedge clk);
    bus.in_valid = v;
    bus.din_r    = r;
    bus.din_i    = i;
    check("tw_idx", bus.tw_idx, idx % 16);
    @(posedge clk);
    #1;
    expv = 1'b0;
    if (v) begin
      expv   = (idx >= 16);
      ph_exp = (idx < 16) ? 0 : ((idx % 32 >= 16) ? 1 : 2);
      idx++;
    end
    check("dout_valid", bus.dout_valid, expv);
    check("phase", bus.phase, ph_exp);
    if (expv && bus.dout_valid === 1'b1) begin
      if (er.size() == 0) begin
        fails++;
        $error("FAIL extra_output: got %0d expected none", bus.dout_r);
      end else begin
        check("dout_r", bus.dout_r, er.pop_front());
        check("dout_i", bus.dout_i, ei.pop_front());
      end
      gr.push_back(bus.dout_r);
      gi.push_back(bus.dout_i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", bus.dout_valid, 0);
    check("rst_dout_r", bus.dout_r, 0);
    check("rst_dout_i", bus.dout_i, 0);
    check("rst_phase", bus.phase, 0);
    check("rst_tw_idx", bus.tw_idx, 0);
    @(negedge clk);
    rst    = 1'b0;
    idx    = 0;
    ph_exp = 0;
    er.delete();
    ei.delete();
    gr.delete();
    gi.delete();
  endtask

  // mode 0: no stalls, 1: 3-cycle stalls at cnt 7/20/31, 2: random stalls
  task automatic play(input int mode);
    logic signed [23:0] r, i;
    for (int n = 0; n < sr.size() + 16; n++) begin
      if (mode == 1 && n < 32 && (n == 7 || n == 20 || n == 31))
        repeat (3) send(1'b0, 24'($urandom), 24'($urandom));
      if (mode == 2 && $urandom_range(0, 3) == 0)
        send(1'b0, 24'($urandom), 24'($urandom));
      r = (n < sr.size()) ? sr[n] : 24'sd0;
      i = (n < sr.size()) ? si[n] : 24'sd0;
      send(1'b1, r, i);
    end
    check("drained", er.size(), 0);
  endtask

  task automatic load_zero(input int nfr);
    sr.delete();
    si.delete();
    for (int n = 0; n < nfr * 32; n++) begin
      sr.push_back(24'sd0);
      si.push_back(24'sd0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.din_r    = '0;
    bus.din_i    = '0;
    idx          = 0;
    ph_exp       = 0;

    do_reset();

    // impulse
    load_zero(2);
    sr[0] = 24'sd256;
    build_expected();
    play(0);
    check("imp_sum0", gr[0], 256);
    check("imp_sum1", gr[1], 0);
    check("imp_tw0_r", gr[16], 256);
    check("imp_tw0_i", gi[16], 0);
    check("imp_tw1", gr[17], 0);

    // twiddle W^1
    do_reset();
    load_zero(1);
    sr[1] = 24'sd256;
    build_expected();
    play(0);
    check("tw_sum1_r", gr[1], 256);
    check("tw_sum1_i", gi[1], 0);
    check("tw_tw1_r", gr[17], 251);
    check("tw_tw1_i", gi[17], -50);

    // DC
    do_reset();
    load_zero(2);
    for (int n = 0; n < 64; n++) begin
      sr[n] = 24'sd100;
      si[n] = -24'sd40;
    end
    build_expected();
    play(0);
    check("dc_sum_r", gr[0], 200);
    check("dc_sum_i", gi[0], -80);
    check("dc_tw_r", gr[16], 0);
    check("dc_tw_i", gi[16], 0);

    // impulse with stalls
    do_reset();
    load_zero(2);
    sr[0] = 24'sd256;
    build_expected();
    play(1);
    check("stall_sum0", gr[0], 256);
    check("stall_tw0", gr[16], 256);

    // reset mid-frame at cnt=22, then clean impulse
    do_reset();
    load_zero(2);
    for (int n = 0; n < 22; n++) begin
      sr[n] = 24'($urandom_range(0, 999));
      si[n] = 24'($urandom_range(0, 999));
    end
    build_expected();
    for (int n = 0; n < 22; n++) send(1'b1, sr[n], si[n]);
    check("pre_rst_cnt", bus.tw_idx, 6);
    do_reset();
    load_zero(2);
    sr[0] = 24'sd256;
    build_expected();
    play(0);
    check("rst_sum0", gr[0], 256);
    check("rst_tw0", gr[16], 256);

    // wrap without saturation
    do_reset();
    load_zero(1);
    sr[0]  = 24'sh7fffff;
    sr[16] = 24'sd1;
    build_expected();
    play(0);
    check("wrap_sum0", gr[0], -(1 <<< 23));
    check("wrap_tw0_r", gr[16], (1 <<< 23) - 2);
    check("wrap_tw0_i", gi[16], 0);

    // random frames, random stalls
    do_reset();
    load_zero(3);
    for (int n = 0; n < 96; n++) begin
      sr[n] = 24'($urandom);
      si[n] = 24'($urandom);
    end
    build_expected();
    play(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
